// File: rtl/async_fifo_pkg.sv
// Shared types for the async FIFO write-side arbiter.
package async_fifo_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid requester searching upward from last_grant+1, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_last_grant,
  output logic [NUM_REQ-1:0]         o_pick,
  output logic                       o_pick_valid
);

  localparam int IDXW = $clog2(NUM_REQ);

  always_comb begin
    logic [IDXW-1:0] w_idx;
    o_pick       = '0;
    o_pick_valid = 1'b0;
    w_idx        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDXW'((int'(i_last_grant) + k) % NUM_REQ);
      if (!o_pick_valid && i_req_valid[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        o_pick_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Handshake: beat i transfers on a cycle where req_valid[i] && req_ready[i]; fifo_wr_en mirrors that transfer.
module async_fifo_wr_arbiter
  import async_fifo_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output arb_state_e                    dbg_state
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int BCW  = $clog2(MAX_BURST) + 1;
  localparam int ICW  = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(MAX_BURST - 1);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_TIMEOUT - 1);

  arb_state_e          r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [IDXW-1:0]     r_g_idx;
  logic [IDXW-1:0]     r_last_grant;
  logic [BCW-1:0]      r_beat_cnt;
  logic [ICW-1:0]      r_idle_cnt;

  logic [NUM_REQ-1:0]  w_pick;
  logic                w_pick_valid;
  logic [IDXW-1:0]     w_pick_idx;
  logic                w_in_burst;
  logic                w_fire;
  logic                w_end_burst;
  logic                w_timeout;
  logic [DATA_WIDTH-1:0] w_din;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .i_req_valid  (req_valid),
    .i_last_grant (r_last_grant),
    .o_pick       (w_pick),
    .o_pick_valid (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = IDXW'(i);
    end
  end

  // AND-OR mux keyed by the one-hot grant; yields zero when no grant is held.
  always_comb begin
    w_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_din = w_din | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}});
    end
  end

  assign w_in_burst  = (r_state == ARB_BURST);
  assign w_fire      = w_in_burst && req_valid[r_g_idx] && !fifo_full && !rst;
  assign w_end_burst = req_last[r_g_idx] || (r_beat_cnt == BEAT_LAST);
  assign w_timeout   = (r_idle_cnt == IDLE_LAST);

  assign fifo_wr_en = w_fire;
  assign fifo_din   = w_din;
  assign req_ready  = (w_in_burst && !fifo_full && !rst) ? r_grant : '0;
  assign grant      = r_grant;
  assign busy       = w_in_burst;
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_g_idx      <= '0;
      r_last_grant <= IDXW'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_idle_cnt   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid && !fifo_almost_full) begin
            r_state    <= ARB_BURST;
            r_grant    <= w_pick;
            r_g_idx    <= w_pick_idx;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
          end
        end
        ARB_BURST: begin
          if (w_fire) begin
            r_idle_cnt <= '0;
            if (w_end_burst) begin
              r_state      <= ARB_IDLE;
              r_grant      <= '0;
              r_last_grant <= r_g_idx;
              r_beat_cnt   <= '0;
            end else begin
              r_beat_cnt <= (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + 1'b1;
            end
          end else if (!fifo_full) begin
            // Owner has nothing to send; release after a bounded wait so others are not locked out.
            if (w_timeout) begin
              r_state      <= ARB_IDLE;
              r_grant      <= '0;
              r_last_grant <= r_g_idx;
              r_beat_cnt   <= '0;
              r_idle_cnt   <= '0;
            end else begin
              r_idle_cnt <= (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Self-checking bench for async_fifo_wr_arbiter: vector table, directed corner cases, random vs. reference model.
module tb_async_fifo_wr_arbiter;
  import async_fifo_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int IT = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_almost_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_din;
  logic [N-1:0]   grant;
  logic           busy;
  arb_state_e     dbg_state;

  always #5 clk = ~clk;

  async_fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_din         (fifo_din),
    .grant            (grant),
    .busy             (busy),
    .dbg_state        (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner = -1 means nobody holds the port.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_beats = 0;
  int m_idle  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] wr_log[$];

  logic [N-1:0] s_grant, s_ready;
  logic         s_wr, s_busy;
  logic [W-1:0] s_din;

  int cnt[N];

  typedef struct {
    logic         rst;
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic         full;
    logic         af;
    logic [W-1:0] d0;
    logic [N-1:0] e_grant;
    logic         e_busy;
    logic         e_wr;
    logic [W-1:0] e_din;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_at(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [W-1:0] slice_at(input logic [N*W-1:0] v, input int i);
    logic [N*W-1:0] t;
    t = v >> (i * W);
    return t[W-1:0];
  endfunction

  function automatic int pick_next();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (bit_at(req_valid, idx)) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] pack_cnt(input logic [3:0] hi_override, input logic use_override);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = N - 1; i >= 0; i--) begin
      v = (v << W) | (N*W)'({use_override ? hi_override : 4'(i), 4'(cnt[i] + (use_override ? 1 : 0))});
    end
    return v;
  endfunction

  task automatic drive(input logic r, input logic [N-1:0] v, input logic [N-1:0] l, input logic f, input logic a);
    rst = r; req_valid = v; req_last = l; fifo_full = f; fifo_almost_full = a;
  endtask

  // One clock: check outputs against the model, then advance the model on the edge.
  task automatic tick();
    logic [N-1:0] e_grant, e_ready;
    logic         e_wr;
    logic [W-1:0] e_din, got;
    #1;
    e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_wr    = !rst && (m_owner >= 0) && bit_at(req_valid, m_owner) && !fifo_full;
    e_ready = (!rst && (m_owner >= 0) && !fifo_full) ? e_grant : '0;
    e_din   = (m_owner >= 0) ? slice_at(req_data, m_owner) : '0;
    s_grant = grant; s_ready = req_ready; s_wr = fifo_wr_en; s_din = fifo_din; s_busy = busy;
    chk("grant", 32'(s_grant), 32'(e_grant));
    chk("busy", 32'(s_busy), 32'(m_owner >= 0));
    chk("req_ready", 32'(s_ready), 32'(e_ready));
    chk("fifo_wr_en", 32'(s_wr), 32'(e_wr));
    if (e_wr) exp_q.push_back(e_din);
    if (s_wr) begin
      wr_log.push_back(s_din);
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL sb_underflow: got write 0x%0h expected none at t=%0t", s_din, $time);
      end else begin
        got = exp_q.pop_front();
        chk("fifo_din", 32'(s_din), 32'(got));
      end
    end
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_beats = 0; m_idle = 0;
    end else if (m_owner < 0) begin
      if (!fifo_almost_full) m_owner = pick_next();
      m_beats = 0; m_idle = 0;
    end else if (e_wr) begin
      m_beats++; m_idle = 0;
      if (bit_at(req_last, m_owner) || m_beats == MB) begin
        m_last = m_owner; m_owner = -1; m_beats = 0;
      end
    end else if (!fifo_full) begin
      m_idle++;
      if (m_idle == IT) begin
        m_last = m_owner; m_owner = -1; m_idle = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b1, '0, '0, 1'b0, 1'b0);
    tick(); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic count_handshakes();
    for (int i = 0; i < N; i++) begin
      if (bit_at(req_valid, i) && bit_at(s_ready, i)) cnt[i]++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    drive(1'b1, '0, '0, 1'b0, 1'b0);
    req_data = '0;

    // Reset with all valid, release, then requester 0 sends a 3-beat packet.
    tbl[0] = '{1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 8'h11, 4'h0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 8'h11, 4'h0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 8'h11, 4'h0, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 8'h11, 4'h1, 1'b1, 1'b1, 8'h11};
    tbl[4] = '{1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 8'h22, 4'h1, 1'b1, 1'b1, 8'h22};
    tbl[5] = '{1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 8'h33, 4'h1, 1'b1, 1'b1, 8'h33};
    tbl[6] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00};

    @(negedge clk);
    for (int r = 0; r < 7; r++) begin
      drive(tbl[r].rst, tbl[r].valid, tbl[r].last, tbl[r].full, tbl[r].af);
      req_data = {24'h0, tbl[r].d0};
      tick();
      chk($sformatf("tbl%0d_grant", r), 32'(s_grant), 32'(tbl[r].e_grant));
      chk($sformatf("tbl%0d_busy", r), 32'(s_busy), 32'(tbl[r].e_busy));
      chk($sformatf("tbl%0d_wr", r), 32'(s_wr), 32'(tbl[r].e_wr));
      if (tbl[r].e_wr) chk($sformatf("tbl%0d_din", r), 32'(s_din), 32'(tbl[r].e_din));
    end

    // Four always-valid requesters: grants 0,1,2,3,0, four beats each.
    do_reset();
    wr_log.delete();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    drive(1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    for (int c = 0; c < 40 && wr_log.size() < 20; c++) begin
      req_data = pack_cnt(4'h0, 1'b0);
      tick();
      count_handshakes();
    end
    chk("rr_beat_count", 32'(wr_log.size()), 32'd20);
    for (int b = 0; b < 20 && b < wr_log.size(); b++) begin
      chk($sformatf("rr_beat%0d", b), 32'(wr_log[b]), 32'({4'((b / 4) % 4), 4'((b / 16) * 4 + b % 4)}));
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();

    // FIFO full for three cycles after beat 2 of a burst.
    do_reset();
    wr_log.delete();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    begin
      int stall_left;
      stall_left = 3;
      for (int c = 0; c < 8; c++) begin
        drive(1'b0, 4'h1, 4'h0, (cnt[0] == 2) && (stall_left > 0), 1'b0);
        req_data = pack_cnt(4'hA, 1'b1);
        tick();
        if (fifo_full) begin
          stall_left--;
          chk("stall_wr_en", 32'(s_wr), 32'd0);
          chk("stall_ready", 32'(s_ready), 32'd0);
        end
        count_handshakes();
      end
      chk("stall_cycles_used", 32'(stall_left), 32'd0);
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    chk("stall_burst_done", 32'(s_busy), 32'd0);
    chk("stall_beat_count", 32'(wr_log.size()), 32'd4);
    for (int b = 0; b < 4 && b < wr_log.size(); b++) begin
      chk($sformatf("stall_beat%0d", b), 32'(wr_log[b]), 32'(8'hA1 + b));
    end

    // Idle timeout hands the port from req1 to pending req2; almost_full blocks new grants.
    do_reset();
    req_data = 32'h4433_2211;
    drive(1'b0, 4'h2, 4'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("to_first_beat", 32'(s_wr), 32'd1);
    drive(1'b0, 4'h4, 4'h0, 1'b0, 1'b0);
    for (int c = 0; c < IT; c++) begin
      tick();
      chk($sformatf("to_hold%0d", c), 32'(s_grant), 32'h2);
    end
    tick();
    chk("to_released", 32'(s_grant), 32'h0);
    drive(1'b0, 4'h4, 4'h4, 1'b0, 1'b0);
    tick();
    chk("to_req2_granted", 32'(s_grant), 32'h4);
    drive(1'b0, 4'hF, 4'h0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("af_no_grant%0d", c), 32'(s_grant), 32'h0);
    end
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b0);
    tick();
    chk("af_fall_arb", 32'(s_grant), 32'h0);
    tick();
    chk("af_then_req3", 32'(s_grant), 32'h8);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();

    // Reset during beat 2 of a burst owned by req2.
    do_reset();
    req_data = 32'hC4C3_C2C1;
    drive(1'b0, 4'h4, 4'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rstmid_beat1", 32'(s_wr), 32'd1);
    drive(1'b1, 4'h4, 4'h0, 1'b0, 1'b0);
    tick();
    chk("rstmid_no_write", 32'(s_wr), 32'd0);
    chk("rstmid_no_ready", 32'(s_ready), 32'd0);
    drive(1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    tick();
    chk("rstmid_grant_cleared", 32'(s_grant), 32'h0);
    tick();
    chk("rstmid_req0_first", 32'(s_grant), 32'h1);
    do_reset();

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 99) == 0), N'($urandom), N'($urandom & $urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      req_data = $urandom;
      tick();
    end
    do_reset();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
